// File: rtl/sreg_tx_pkg.sv
// Shared definitions for the AVR serial shift registers: FSM encoding and frame length.
// SREG_TX_PARITY_EN appends one even-parity bit to every transmitted frame.
package sreg_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } sreg_state_t;

`ifdef SREG_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int addr_width, input int data_width);
        return addr_width + data_width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sreg_tx_div.sv
// Bit-period divider: counts enabled cycles and ticks on the last cycle of each DIV-cycle period.
module sreg_tx_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // A disabled cycle holds the count, which is what freezes a paused frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sreg_tx.sv
// Serial-out transmitter: loads {addr, data} and shifts it MSB-first to the AVR.
// Define SREG_TX_PARITY_EN to append an even-parity bit after the data LSB.
module sreg_tx
    import sreg_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 8,
    parameter int DIV        = 2
) (
    input  logic                  avr_clk,
    input  logic                  avr_reset,
    input  logic                  avr_sreg_en_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  avr_so,
    output logic                  busy,
    output logic                  done
);

    localparam int FRAME_LEN = frame_len(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    sreg_state_t state, next_state;
    logic [FRAME_LEN-1:0] shreg, next_shreg;
    logic [FRAME_LEN-1:0] load_frame;
    logic [CNT_W-1:0]     bit_cnt, next_bit_cnt;
    logic                 tick;
    logic                 div_en;
    logic                 div_clear;

`ifdef SREG_TX_PARITY_EN
    assign load_frame = {addr, data, ^{addr, data}};
`else
    assign load_frame = {addr, data};
`endif

    assign div_en    = (state == SHIFT) && !avr_sreg_en_n;
    assign div_clear = (state != SHIFT);

    sreg_tx_div #(
        .DIV(DIV)
    ) u_div (
        .clk  (avr_clk),
        .reset(avr_reset),
        .clear(div_clear),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            shreg   <= next_shreg;
            bit_cnt <= next_bit_cnt;
        end
    end

    // Loads are honoured only from IDLE, so a frame in flight is never disturbed.
    always_comb begin
        next_state   = state;
        next_shreg   = shreg;
        next_bit_cnt = bit_cnt;
        case (state)
            IDLE: begin
                if (load && !avr_sreg_en_n) begin
                    next_shreg   = load_frame;
                    next_bit_cnt = '0;
                    next_state   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    next_shreg   = {shreg[FRAME_LEN-2:0], 1'b0};
                    next_bit_cnt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_bit_cnt = '0;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign avr_so = (state == SHIFT) && shreg[FRAME_LEN-1];
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

endmodule
